// File: rtl/regfile_arbiter.sv
// regfile_arbiter: two-requester round-robin sequencer in front of an 8x16 register file
//   CLK, RST                     clock; synchronous active-low reset
//   ReqX, WrX, AddrX, WrDataX    requester X command (X = A or B), held until AckX
//   AckX, RdDataX, RdValidX      accept pulse, last read result, read-result pulse
//   RF_WrEn, RF_RdEn             register file strobes, one cycle each
//   RF_Address, RF_WrData        latched command address and write data
//   RF_RdData                    registered register file read data
//   Busy                         an access is in flight
module regfile_arbiter #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  ReqA,
  input  logic                  WrA,
  input  logic [ADDR_WIDTH-1:0] AddrA,
  input  logic [DATA_WIDTH-1:0] WrDataA,
  output logic                  AckA,
  output logic [DATA_WIDTH-1:0] RdDataA,
  output logic                  RdValidA,
  input  logic                  ReqB,
  input  logic                  WrB,
  input  logic [ADDR_WIDTH-1:0] AddrB,
  input  logic [DATA_WIDTH-1:0] WrDataB,
  output logic                  AckB,
  output logic [DATA_WIDTH-1:0] RdDataB,
  output logic                  RdValidB,
  output logic                  RF_WrEn,
  output logic                  RF_RdEn,
  output logic [ADDR_WIDTH-1:0] RF_Address,
  output logic [DATA_WIDTH-1:0] RF_WrData,
  input  logic [DATA_WIDTH-1:0] RF_RdData,
  output logic                  Busy
);
  typedef enum logic [1:0] {IDLE, WRITE, READ, RD_WAIT} stateT;
  stateT state, nextState;
  // last doubles as the owner of the access in flight: 1 = B
  logic last, nextLast;
  logic pickB, pickWr;
  logic nextAckA, nextAckB, nextRdValidA, nextRdValidB, nextWrEn, nextRdEn;
  logic [ADDR_WIDTH-1:0] nextAddress;
  logic [DATA_WIDTH-1:0] nextWrData, nextRdDataA, nextRdDataB;
  always_comb begin
    pickB = ReqB & (~ReqA | ~last);
    pickWr = pickB ? WrB : WrA;
    nextState = state;
    nextLast = last;
    nextAckA = 1'b0;
    nextAckB = 1'b0;
    nextRdValidA = 1'b0;
    nextRdValidB = 1'b0;
    nextWrEn = 1'b0;
    nextRdEn = 1'b0;
    nextAddress = RF_Address;
    nextWrData = RF_WrData;
    nextRdDataA = RdDataA;
    nextRdDataB = RdDataB;
    case (state)
      IDLE: if (ReqA | ReqB) begin
        nextState = pickWr ? WRITE : READ;
        nextLast = pickB;
        nextAddress = pickB ? AddrB : AddrA;
        nextWrData = pickB ? WrDataB : WrDataA;
        nextAckA = ~pickB;
        nextAckB = pickB;
        nextWrEn = pickWr;
        nextRdEn = ~pickWr;
      end
      WRITE: nextState = IDLE;
      READ: nextState = RD_WAIT;
      RD_WAIT: begin
        nextState = IDLE;
        nextRdDataA = last ? RdDataA : RF_RdData;
        nextRdDataB = last ? RF_RdData : RdDataB;
        nextRdValidA = ~last;
        nextRdValidB = last;
      end
      default: nextState = IDLE;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state <= IDLE;
      last <= 1'b1;
      AckA <= 1'b0;
      AckB <= 1'b0;
      RdValidA <= 1'b0;
      RdValidB <= 1'b0;
      RdDataA <= '0;
      RdDataB <= '0;
      RF_WrEn <= 1'b0;
      RF_RdEn <= 1'b0;
      RF_Address <= '0;
      RF_WrData <= '0;
      Busy <= 1'b0;
    end else begin
      state <= nextState;
      last <= nextLast;
      AckA <= nextAckA;
      AckB <= nextAckB;
      RdValidA <= nextRdValidA;
      RdValidB <= nextRdValidB;
      RdDataA <= nextRdDataA;
      RdDataB <= nextRdDataB;
      RF_WrEn <= nextWrEn;
      RF_RdEn <= nextRdEn;
      RF_Address <= nextAddress;
      RF_WrData <= nextWrData;
      Busy <= nextState != IDLE;
    end
  end
endmodule

// File: tb/tb_regfile_arbiter.sv
// tb_regfile_arbiter: randomized and directed checks of regfile_arbiter against a transaction-level model
module tb_regfile_arbiter;
  logic CLK, RST;
  logic ReqA, WrA, AckA, RdValidA, ReqB, WrB, AckB, RdValidB;
  logic [2:0] AddrA, AddrB, RF_Address;
  logic [15:0] WrDataA, WrDataB, RdDataA, RdDataB, RF_WrData, RF_RdData;
  logic RF_WrEn, RF_RdEn, Busy;
  int checks = 0;
  int passes = 0;

  regfile_arbiter dut (
    .CLK(CLK), .RST(RST),
    .ReqA(ReqA), .WrA(WrA), .AddrA(AddrA), .WrDataA(WrDataA),
    .AckA(AckA), .RdDataA(RdDataA), .RdValidA(RdValidA),
    .ReqB(ReqB), .WrB(WrB), .AddrB(AddrB), .WrDataB(WrDataB),
    .AckB(AckB), .RdDataB(RdDataB), .RdValidB(RdValidB),
    .RF_WrEn(RF_WrEn), .RF_RdEn(RF_RdEn), .RF_Address(RF_Address),
    .RF_WrData(RF_WrData), .RF_RdData(RF_RdData), .Busy(Busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // register file the arbiter drives; it shares the system reset
  logic [15:0] rf [8] = '{default: 16'h0};
  always @(posedge CLK) begin
    if (RST && RF_WrEn) rf[RF_Address] <= RF_WrData;
    if (RF_RdEn) RF_RdData <= rf[RF_Address];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // transaction model: an access occupies the arbiter for a fixed number of cycles
  // (write 1, read 2); completion commits the write or delivers the read data
  logic mOn = 1'b0;
  logic mAckA, mAckB, mValA, mValB, mWrEn, mRdEn, mLastB, mOwnerB, mOpWr;
  logic [2:0] mAddr;
  logic [15:0] mWrData, mRdDataA, mRdDataB;
  logic [15:0] mMem [8] = '{default: 16'h0};
  int remain = 0;
  always @(posedge CLK) begin
    if (!RST) begin
      mOn = 1'b1;
      {mAckA, mAckB, mValA, mValB, mWrEn, mRdEn} = '0;
      mAddr = '0;
      mWrData = '0;
      mRdDataA = '0;
      mRdDataB = '0;
      mLastB = 1'b1;
      remain = 0;
    end else if (mOn) begin
      {mAckA, mAckB, mValA, mValB, mWrEn, mRdEn} = '0;
      if (remain > 0) begin
        remain--;
        if (remain == 0 && mOpWr) mMem[mAddr] = mWrData;
        if (remain == 0 && !mOpWr && mOwnerB) begin mRdDataB = mMem[mAddr]; mValB = 1'b1; end
        if (remain == 0 && !mOpWr && !mOwnerB) begin mRdDataA = mMem[mAddr]; mValA = 1'b1; end
      end else if (ReqA || ReqB) begin
        mOwnerB = (ReqA && ReqB) ? !mLastB : ReqB;
        mLastB = mOwnerB;
        mOpWr = mOwnerB ? WrB : WrA;
        mAddr = mOwnerB ? AddrB : AddrA;
        mWrData = mOwnerB ? WrDataB : WrDataA;
        mAckA = !mOwnerB;
        mAckB = mOwnerB;
        mWrEn = mOpWr;
        mRdEn = !mOpWr;
        remain = mOpWr ? 1 : 2;
      end
    end
  end

  always @(negedge CLK) if (mOn) begin
    chk("AckA", 32'(AckA), 32'(mAckA));
    chk("AckB", 32'(AckB), 32'(mAckB));
    chk("RdValidA", 32'(RdValidA), 32'(mValA));
    chk("RdValidB", 32'(RdValidB), 32'(mValB));
    chk("RdDataA", 32'(RdDataA), 32'(mRdDataA));
    chk("RdDataB", 32'(RdDataB), 32'(mRdDataB));
    chk("RF_WrEn", 32'(RF_WrEn), 32'(mWrEn));
    chk("RF_RdEn", 32'(RF_RdEn), 32'(mRdEn));
    chk("RF_Address", 32'(RF_Address), 32'(mAddr));
    chk("RF_WrData", 32'(RF_WrData), 32'(mWrData));
    chk("Busy", 32'(Busy), 32'(remain != 0));
  end

  initial begin
    int order[$];
    int grantWho[$];
    int grantCyc[$];
    logic seen;
    RST = 1'b0;
    ReqA = 1'b1; WrA = 1'b0; AddrA = '0; WrDataA = '0;
    ReqB = 1'b1; WrB = 1'b0; AddrB = '0; WrDataB = '0;
    repeat (2) begin
      @(negedge CLK);
      chk("t1_busy", 32'(Busy), 0);
      chk("t1_ackA", 32'(AckA), 0);
      chk("t1_ackB", 32'(AckB), 0);
      chk("t1_outs", 32'({RF_WrEn, RF_RdEn, RF_Address, RF_WrData, RdDataA}), 0);
    end
    ReqA = 1'b0; ReqB = 1'b0; RST = 1'b1;
    ReqA = 1'b1; WrA = 1'b1; AddrA = 3'd3; WrDataA = 16'h000B;
    @(negedge CLK);
    chk("t2_ackA", 32'(AckA), 1);
    chk("t2_wren", 32'(RF_WrEn), 1);
    chk("t2_addr", 32'(RF_Address), 3);
    chk("t2_wrdata", 32'(RF_WrData), 32'h000B);
    ReqA = 1'b0;
    @(negedge CLK);
    chk("t2_wren_off", 32'(RF_WrEn), 0);
    chk("t2_reg3", 32'(rf[3]), 32'h000B);
    ReqA = 1'b1; WrA = 1'b0; AddrA = 3'd3;
    @(negedge CLK);
    chk("t3_ackA", 32'(AckA), 1);
    chk("t3_rden", 32'(RF_RdEn), 1);
    chk("t3_addr", 32'(RF_Address), 3);
    ReqA = 1'b0;
    @(negedge CLK);
    chk("t3_early_valid", 32'(RdValidA), 0);
    @(negedge CLK);
    chk("t3_validA", 32'(RdValidA), 1);
    chk("t3_rdDataA", 32'(RdDataA), 32'h000B);
    chk("t3_validB", 32'(RdValidB), 0);
    RST = 1'b0;
    @(negedge CLK);
    RST = 1'b1;
    ReqA = 1'b1; WrA = 1'b1; AddrA = 3'd7; WrDataA = 16'hFFFF;
    ReqB = 1'b1; WrB = 1'b0; AddrB = 3'd7;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge CLK);
      if (AckA) begin order.push_back(0); ReqA = 1'b0; end
      if (AckB) begin order.push_back(1); ReqB = 1'b0; end
      if (RdValidB) begin
        seen = 1'b1;
        chk("t4_rdDataB", 32'(RdDataB), 32'hFFFF);
        chk("t4_rdDataA", 32'(RdDataA), 0);
      end
    end
    ReqA = 1'b0; ReqB = 1'b0;
    chk("t4_validB_seen", 32'(seen), 1);
    chk("t4_grants", 32'(order.size()), 2);
    chk("t4_first", 32'(order.size() > 0 ? order[0] : -1), 0);
    chk("t4_second", 32'(order.size() > 1 ? order[1] : -1), 1);
    @(negedge CLK);
    ReqB = 1'b1; WrB = 1'b0; AddrB = 3'd7;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge CLK);
      seen = AckB;
    end
    ReqB = 1'b0;
    chk("t6_ackB_seen", 32'(seen), 1);
    @(negedge CLK);
    chk("t6_busy_rdwait", 32'(Busy), 1);
    RST = 1'b0;
    @(negedge CLK);
    RST = 1'b1;
    chk("t6_busy", 32'(Busy), 0);
    chk("t6_rdDataB", 32'(RdDataB), 0);
    chk("t6_rden", 32'(RF_RdEn), 0);
    repeat (3) begin
      @(negedge CLK);
      chk("t6_no_validB", 32'(RdValidB), 0);
    end
    ReqA = 1'b1; WrA = 1'b0; AddrA = 3'd0;
    ReqB = 1'b1; WrB = 1'b0; AddrB = 3'd0;
    for (int c = 0; c < 40 && grantWho.size() < 6; c++) begin
      @(negedge CLK);
      if (AckA) begin grantWho.push_back(0); grantCyc.push_back(c); end
      if (AckB) begin grantWho.push_back(1); grantCyc.push_back(c); end
    end
    ReqA = 1'b0; ReqB = 1'b0;
    chk("t5_grants", 32'(grantWho.size()), 6);
    for (int i = 0; i < grantWho.size(); i++) chk("t5_alternate", 32'(grantWho[i]), 32'(i % 2));
    for (int i = 1; i < grantCyc.size(); i++) chk("t5_spacing", 32'(grantCyc[i] - grantCyc[i-1]), 3);
    repeat (4) @(negedge CLK);
    for (int c = 0; c < 3000; c++) begin
      @(negedge CLK);
      if (!RST) RST = 1'b1;
      else if ($urandom_range(0, 299) == 0) RST = 1'b0;
      if (!ReqA || AckA) begin
        ReqA = 1'($urandom_range(0, 1));
        WrA = 1'($urandom_range(0, 1));
        AddrA = 3'($urandom_range(0, 7));
        WrDataA = 16'($urandom);
      end
      if (!ReqB || AckB) begin
        ReqB = 1'($urandom_range(0, 1));
        WrB = 1'($urandom_range(0, 1));
        AddrB = 3'($urandom_range(0, 7));
        WrDataB = 16'($urandom);
      end
    end
    ReqA = 1'b0; ReqB = 1'b0; RST = 1'b1;
    repeat (5) @(negedge CLK);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
